// File: rtl/output_arbiter.sv
// Per-output arbiter: picks one of NUM_PORTS requesting input buffers, starting the
// search at the one-hot priority_val, and holds that grant until the end-of-packet flit.
// Latency: arbitration takes one edge (IDLE -> LOCKED). rd_en to data_valid is one cycle.
// Backpressure: out_ready low blocks rd_en, so the lock holds and no flit moves.
//
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   req, eop      per-input request (buffer non-empty for this output) and head-is-last flag
//   data_in       flattened head flits, port i at [i*DATAWIDTH +: DATAWIDTH]
//   priority_val  one-hot start position for the scan (non-one-hot falls back to port 0)
//   out_ready     output buffer can take a flit this cycle
//   grant         registered one-hot owner of this output; 0 while idle
//   rd_en         combinational pop to the granted input buffer
//   change_prio   one-cycle pulse when an arbitration had two or more contenders
//   data_out      registered flit to the output buffer, qualified by data_valid
//   busy          high while a packet holds the output
module output_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int DATAWIDTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_PORTS-1:0]           req,
  input  logic [NUM_PORTS-1:0]           eop,
  input  logic [NUM_PORTS*DATAWIDTH-1:0] data_in,
  input  logic [NUM_PORTS-1:0]           priority_val,
  input  logic                           out_ready,
  output logic [NUM_PORTS-1:0]           grant,
  output logic [NUM_PORTS-1:0]           rd_en,
  output logic                           change_prio,
  output logic [DATAWIDTH-1:0]           data_out,
  output logic                           data_valid,
  output logic                           busy
);

  localparam int IW = $clog2(NUM_PORTS);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t               state;
  logic [IW-1:0]        start_idx;
  logic [IW:0]          prio_count;
  logic [IW-1:0]        scan_idx;
  logic                 found;
  logic [NUM_PORTS-1:0] winner;
  logic [IW:0]          req_count;
  logic [DATAWIDTH-1:0] granted_data;
  logic                 granted_eop;

  // Start position: bit index of priority_val when exactly one bit is set, else 0.
  always_comb begin
    start_idx  = '0;
    prio_count = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (priority_val[i]) begin
        prio_count = prio_count + 1'b1;
        start_idx  = IW'(i);
      end
    end
    if (prio_count != (IW+1)'(1)) begin
      start_idx = '0;
    end
  end

  // Circular scan from start_idx; the index wraps naturally because NUM_PORTS is a power of two.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      scan_idx = start_idx + IW'(k);
      if (!found && req[scan_idx]) begin
        winner[scan_idx] = 1'b1;
        found            = 1'b1;
      end
    end
  end

  // Number of contenders, used only to decide whether the decider should rotate.
  always_comb begin
    req_count = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      req_count = req_count + (IW+1)'(req[i]);
    end
  end

  // Head flit and eop of the locked port.
  always_comb begin
    granted_data = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) begin
        granted_data = data_in[i*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

  assign granted_eop = |(grant & eop);

  // Only the locked port may pop; other requesters are ignored until the next IDLE.
  assign rd_en = (state == LOCKED && out_ready) ? (grant & req) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      change_prio <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          data_valid <= 1'b0;
          if (|req) begin
            grant       <= winner;
            state       <= LOCKED;
            busy        <= 1'b1;
            change_prio <= (req_count >= (IW+1)'(2));
          end else begin
            change_prio <= 1'b0;
          end
        end
        LOCKED: begin
          change_prio <= 1'b0;
          if (|rd_en) begin
            data_out   <= granted_data;
            data_valid <= 1'b1;
            // Release after the last flit; the next packet needs a fresh IDLE arbitration.
            if (granted_eop) begin
              state <= IDLE;
              grant <= '0;
              busy  <= 1'b0;
            end
          end else begin
            data_valid <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_output_arbiter.sv
module tb_output_arbiter;

  localparam int NP = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [NP-1:0]   req;
  logic [NP-1:0]   eop;
  logic [NP*DW-1:0] data_in;
  logic [NP-1:0]   priority_val;
  logic            out_ready;
  logic [NP-1:0]   grant;
  logic [NP-1:0]   rd_en;
  logic            change_prio;
  logic [DW-1:0]   data_out;
  logic            data_valid;
  logic            busy;

  always #5 clk = ~clk;

  output_arbiter #(.NUM_PORTS(NP), .DATAWIDTH(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .eop          (eop),
    .data_in      (data_in),
    .priority_val (priority_val),
    .out_ready    (out_ready),
    .grant        (grant),
    .rd_en        (rd_en),
    .change_prio  (change_prio),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .busy         (busy)
  );

  // Input buffers feeding the arbiter: {eop, flit} per entry.
  logic [8:0]    bufq [NP][$];
  logic [NP-1:0] mask;
  logic [NP-1:0] prio_cfg;
  logic [NP-1:0] rr_prio;
  bit            rr_mode;

  int checks   = 0;
  int failures = 0;

  // Reference model: owner port index (-1 = free) plus the registered outputs.
  int         lock;
  logic       m_cp, m_dv;
  logic [7:0] m_dout;
  bit         model_ok;

  logic [7:0] dv_log [$];
  logic [3:0] grant_log [$];
  int         cp_count;
  logic [3:0] last_grant;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] m_grant();
    return (lock < 0) ? 4'b0000 : (4'b0001 << lock);
  endfunction

  function automatic logic [3:0] exp_rd();
    if (lock >= 0 && out_ready && req[lock]) return 4'b0001 << lock;
    return 4'b0000;
  endfunction

  // Rotating search: first requester at or after the priority position, wrapping round.
  function automatic int pick();
    int p = 0;
    if ($countones(priority_val) == 1)
      for (int i = 0; i < NP; i++) if (priority_val[i]) p = i;
    for (int k = 0; k < NP; k++) if (req[(p + k) % NP]) return (p + k) % NP;
    return -1;
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < NP; i++) if (bufq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic refresh();
    for (int i = 0; i < NP; i++) begin
      if (bufq[i].size() > 0 && !mask[i]) begin
        req[i]            = 1'b1;
        eop[i]            = bufq[i][0][8];
        data_in[i*DW +: DW] = bufq[i][0][7:0];
      end else begin
        req[i]            = 1'b0;
        eop[i]            = 1'b0;
        data_in[i*DW +: DW] = 8'hEE;
      end
    end
    priority_val = rr_mode ? rr_prio : prio_cfg;
  endtask

  task automatic push(input int p, input logic [7:0] d, input logic e);
    bufq[p].push_back({e, d});
  endtask

  // One clock: advance model and buffers at the edge, then compare all outputs just after it.
  task automatic tick();
    logic [3:0] rdv;
    logic       cp_was;
    int         w;
    refresh();
    @(posedge clk);
    rdv    = exp_rd();
    cp_was = m_cp;
    if (reset) begin
      lock = -1; m_cp = 1'b0; m_dv = 1'b0; m_dout = 8'h00; model_ok = 1'b1;
    end else if (lock < 0) begin
      m_dv = 1'b0;
      w    = pick();
      m_cp = (w >= 0) && ($countones(req) >= 2);
      lock = w;
    end else begin
      m_cp = 1'b0;
      if (rdv != 4'b0000) begin
        m_dout = data_in[lock*DW +: DW];
        m_dv   = 1'b1;
        if (eop[lock]) lock = -1;
      end else begin
        m_dv = 1'b0;
      end
    end
    if (!reset) begin
      if (rr_mode && cp_was) rr_prio = {rr_prio[2:0], rr_prio[3]};
      for (int i = 0; i < NP; i++) if (rdv[i]) void'(bufq[i].pop_front());
    end
    #1 refresh();
    #1;
    if (model_ok) begin
      check("grant",       32'(grant),       32'(m_grant()));
      check("rd_en",       32'(rd_en),       32'(exp_rd()));
      check("change_prio", 32'(change_prio), 32'(m_cp));
      check("data_valid",  32'(data_valid),  32'(m_dv));
      check("busy",        32'(busy),        32'(lock >= 0));
      if (m_dv) check("data_out", 32'(data_out), 32'(m_dout));
    end
    if (data_valid) dv_log.push_back(data_out);
    if (grant != 4'b0000 && last_grant == 4'b0000) grant_log.push_back(grant);
    last_grant = grant;
    if (change_prio) cp_count++;
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n = 0;
    while (!(all_empty() && !busy && !data_valid) && n < bound) begin
      tick();
      n++;
    end
    check({name, "_idle_timeout"}, 32'(all_empty() && !busy && !data_valid), 32'd1);
  endtask

  task automatic wait_dv(input string name, input int target, input int bound);
    int n = 0;
    while (dv_log.size() < target && n < bound) begin
      tick();
      n++;
    end
    check({name, "_dv_timeout"}, 32'(dv_log.size() >= target), 32'd1);
  endtask

  initial begin
    int d0, g0, c0, n;
    reset = 1'b1; mask = '0; prio_cfg = 4'b0001; rr_mode = 1'b0; rr_prio = 4'b0001;
    out_ready = 1'b1; lock = -1; m_cp = 1'b0; m_dv = 1'b0; m_dout = 8'h00; model_ok = 1'b0;
    cp_count = 0; last_grant = 4'b0000;
    tick(); tick();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy",  32'(busy),  32'h0);
    check("rst_dv",    32'(data_valid), 32'h0);
    check("rst_cp",    32'(change_prio), 32'h0);
    check("rst_dout",  32'(data_out), 32'h0);
    reset = 1'b0;

    // Single requester, 3-flit packet.
    d0 = dv_log.size(); c0 = cp_count;
    prio_cfg = 4'b0001;
    push(2, 8'hA1, 1'b0); push(2, 8'hA2, 1'b0); push(2, 8'hA3, 1'b1);
    tick();
    check("s1_grant", 32'(grant), 32'h4);
    check("s1_cp",    32'(change_prio), 32'h0);
    wait_idle("s1", 20);
    check("s1_count", 32'(dv_log.size() - d0), 32'd3);
    check("s1_f0", 32'(dv_log[d0]),   32'hA1);
    check("s1_f1", 32'(dv_log[d0+1]), 32'hA2);
    check("s1_f2", 32'(dv_log[d0+2]), 32'hA3);
    check("s1_cp_total", 32'(cp_count - c0), 32'd0);
    check("s1_grant_end", 32'(grant), 32'h0);

    // Contention: req=1010, priority at 2, scan wins at 3.
    d0 = dv_log.size(); g0 = grant_log.size(); c0 = cp_count;
    prio_cfg = 4'b0100;
    push(1, 8'h11, 1'b1); push(3, 8'h33, 1'b1);
    tick();
    check("s2_grant", 32'(grant), 32'h8);
    check("s2_cp_hi", 32'(change_prio), 32'h1);
    tick();
    check("s2_cp_lo", 32'(change_prio), 32'h0);
    wait_idle("s2", 20);
    check("s2_g0", 32'(grant_log[g0]),   32'h8);
    check("s2_g1", 32'(grant_log[g0+1]), 32'h2);
    check("s2_cp_total", 32'(cp_count - c0), 32'd1);
    check("s2_f0", 32'(dv_log[d0]),   32'h33);
    check("s2_f1", 32'(dv_log[d0+1]), 32'h11);

    // Round robin with a rotating decider and all four ports requesting.
    d0 = dv_log.size(); g0 = grant_log.size(); c0 = cp_count;
    rr_prio = 4'b0001; rr_mode = 1'b1;
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < NP; i++) push(i, 8'h40 + 8'(16*i + j), 1'b1);
    wait_idle("s3", 60);
    for (int k = 0; k < 8; k++)
      check($sformatf("s3_g%0d", k), 32'(grant_log[g0+k]), 32'h1 << (k % 4));
    check("s3_cp_total", 32'(cp_count - c0), 32'd7);
    check("s3_f0", 32'(dv_log[d0]),   32'h40);
    check("s3_f1", 32'(dv_log[d0+1]), 32'h50);
    check("s3_f4", 32'(dv_log[d0+4]), 32'h41);
    rr_mode = 1'b0;

    // Backpressure: stall three cycles mid-packet.
    d0 = dv_log.size();
    prio_cfg = 4'b0001;
    push(0, 8'hB1, 1'b0); push(0, 8'hB2, 1'b0); push(0, 8'hB3, 1'b0); push(0, 8'hB4, 1'b1);
    wait_dv("s4", d0 + 2, 20);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("s4_rd%0d", k),    32'(rd_en), 32'h0);
      check($sformatf("s4_dv%0d", k),    32'(data_valid), 32'h0);
      check($sformatf("s4_grant%0d", k), 32'(grant), 32'h1);
    end
    out_ready = 1'b1;
    wait_idle("s4", 20);
    check("s4_count", 32'(dv_log.size() - d0), 32'd4);
    for (int k = 0; k < 4; k++)
      check($sformatf("s4_f%0d", k), 32'(dv_log[d0+k]), 32'hB1 + 32'(k));

    // Illegal priority falls back to index 0; granted request drops for two cycles.
    d0 = dv_log.size();
    prio_cfg = 4'b0000;
    push(1, 8'hC1, 1'b0); push(1, 8'hC2, 1'b1); push(2, 8'hD1, 1'b1);
    tick();
    check("s5_grant", 32'(grant), 32'h2);
    check("s5_cp",    32'(change_prio), 32'h1);
    mask = 4'b0010;
    for (int k = 0; k < 2; k++) begin
      tick();
      check($sformatf("s5_hold%0d", k), 32'(grant), 32'h2);
      check($sformatf("s5_busy%0d", k), 32'(busy), 32'h1);
      check($sformatf("s5_dv%0d", k),   32'(data_valid), 32'h0);
      check($sformatf("s5_rd%0d", k),   32'(rd_en), 32'h0);
    end
    mask = 4'b0000;
    wait_idle("s5", 20);
    check("s5_f0", 32'(dv_log[d0]),   32'hC1);
    check("s5_f1", 32'(dv_log[d0+1]), 32'hC2);
    check("s5_f2", 32'(dv_log[d0+2]), 32'hD1);

    // Reset after the second of four flits.
    d0 = dv_log.size();
    prio_cfg = 4'b0001;
    push(3, 8'hE1, 1'b0); push(3, 8'hE2, 1'b0); push(3, 8'hE3, 1'b0); push(3, 8'hE4, 1'b1);
    wait_dv("s6", d0 + 2, 20);
    reset = 1'b1;
    tick();
    check("s6_grant", 32'(grant), 32'h0);
    check("s6_busy",  32'(busy),  32'h0);
    check("s6_dv",    32'(data_valid), 32'h0);
    check("s6_cp",    32'(change_prio), 32'h0);
    reset = 1'b0;
    n = 0;
    while (grant == 4'b0000 && n < 10) begin
      tick();
      n++;
    end
    check("s6_regrant", 32'(grant), 32'h8);
    wait_idle("s6", 20);
    check("s6_last", 32'(dv_log[dv_log.size()-1]), 32'hE4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
